// File: rtl/accum_seq.sv
// Command sequencer driving an external accumulator (B/E/S/ACC_CLR) for CLEAR, ADDN, SUBN and DIV.
// Define ACCUM_SEQ_OVF_EN to abort ADDN/SUBN on carry/borrow with OVF=1; otherwise arithmetic wraps.
module accum_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [WIDTH-1:0] CMD_B,
    input  logic [CNT_W-1:0] CMD_N,
    input  logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] B,
    output logic             E,
    output logic             S,
    output logic             ACC_CLR,
    output logic             DONE,
    output logic [CNT_W-1:0] RESULT,
    output logic             DZ,
    output logic             OVF
);

    typedef enum logic [2:0] {IDLE, CLRS, ADD, SUB, DIV, FIN} state_t;
    typedef enum logic [1:0] {OP_CLEAR = 2'b00, OP_ADDN = 2'b01, OP_SUBN = 2'b10, OP_DIV = 2'b11} op_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] result_inc;
    logic             ovf_hit;
    logic             e_w;
    op_t              op;

    assign op = op_t'(CMD_OP);

    // Saturates so a quotient wider than CNT_W pins at all-ones.
    assign result_inc = (result_q == '1) ? result_q : result_q + CNT_W'(1);

`ifdef ACCUM_SEQ_OVF_EN
    logic [WIDTH:0] sum_w;
    assign sum_w   = {1'b0, Q} + {1'b0, b_q};
    assign ovf_hit = (state_q == ADD) ? sum_w[WIDTH] : (b_q > Q);
`else
    assign ovf_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q  <= IDLE;
            b_q      <= '0;
            s_q      <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        e_w      = 1'b0;
        case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    b_d      = CMD_B;
                    s_d      = (op == OP_SUBN) || (op == OP_DIV);
                    cnt_d    = CMD_N;
                    result_d = '0;
                    dz_d     = 1'b0;
                    ovf_d    = 1'b0;
                    // Zero-work commands skip straight to FIN so DONE lands one cycle after accept.
                    case (op)
                        OP_CLEAR: state_d = CLRS;
                        OP_ADDN:  state_d = (CMD_N == '0) ? FIN : ADD;
                        OP_SUBN:  state_d = (CMD_N == '0) ? FIN : SUB;
                        default: begin
                            if (CMD_B == '0) begin
                                dz_d    = 1'b1;
                                state_d = FIN;
                            end else if (Q < CMD_B) begin
                                state_d = FIN;
                            end else begin
                                state_d = DIV;
                            end
                        end
                    endcase
                end
            end
            CLRS: state_d = FIN;
            ADD, SUB: begin
                if (cnt_q == '0) begin
                    state_d = FIN;
                end else if (ovf_hit) begin
                    ovf_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    e_w      = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    result_d = result_inc;
                    if (cnt_q == CNT_W'(1)) state_d = FIN;
                end
            end
            DIV: begin
                if (Q >= b_q) begin
                    e_w      = 1'b1;
                    result_d = result_inc;
                    // Leave on the last subtract rather than one cycle later, keeping DONE at q+1.
                    if ((Q - b_q) < b_q) state_d = FIN;
                end else begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign CMD_READY = (state_q == IDLE);
    assign ACC_CLR   = (state_q == CLRS);
    assign DONE      = (state_q == FIN);
    assign E         = e_w;
    assign B         = b_q;
    assign S         = s_q;
    assign RESULT    = result_q;
    assign DZ        = dz_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_accum_seq.sv
// Directed bench for accum_seq with a behavioural accumulator closing the Q feedback loop.
// Expectations follow ACCUM_SEQ_OVF_EN when it is defined.
module tb_accum_seq;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_ADDN  = 2'b01;
    localparam logic [1:0] OP_SUBN  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    logic       CLK = 1'b0;
    logic       CLR_N = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [1:0] CMD_OP = 2'b00;
    logic [7:0] CMD_B = '0;
    logic [7:0] CMD_N = '0;
    logic [7:0] Q;
    logic [7:0] B;
    logic       E, S, ACC_CLR, DONE, DZ, OVF;
    logic [7:0] RESULT;
    logic [7:0] acc = 8'd0;

    int vectors = 0;
    int errors  = 0;

    accum_seq #(.WIDTH(8), .CNT_W(8)) dut (
        .CLK(CLK), .CLR_N(CLR_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_B(CMD_B), .CMD_N(CMD_N), .Q(Q), .B(B), .E(E), .S(S),
        .ACC_CLR(ACC_CLR), .DONE(DONE), .RESULT(RESULT), .DZ(DZ), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    // Accumulator is not reset by CLR_N.
    always @(posedge CLK) begin
        if (ACC_CLR) acc <= 8'd0;
        else if (E)  acc <= S ? acc - B : acc + B;
    end
    assign Q = acc;

    // Issues one command and reports the cycle of DONE (-1 on timeout) and the E count.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] b, input logic [7:0] n,
                           output int cyc, output int ecnt, output bit proto_bad);
        logic exp_s;
        exp_s = (op == OP_SUBN) || (op == OP_DIV);
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_OP = op; CMD_B = b; CMD_N = n;
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        cyc = -1; ecnt = 0; proto_bad = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge CLK);
            if (E) begin
                ecnt++;
                if (S !== exp_s || B !== b) proto_bad = 1'b1;
            end
            if (DONE) begin
                if (E) proto_bad = 1'b1;
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", CMD_READY); end
        vectors++; if ({E, ACC_CLR, DONE} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {E, ACC_CLR, DONE}); end
        vectors++; if ({B, S, RESULT, DZ, OVF} !== 19'd0) begin errors++; $display("FAIL reset_regs B=%0d S=%b RESULT=%0d DZ=%b OVF=%b exp all 0", B, S, RESULT, DZ, OVF); end
        @(negedge CLK); CLR_N = 1'b1;
    endtask

    task automatic test_clear_add_div();
        int cyc, ec; bit pb;
        run_cmd(OP_CLEAR, 8'd0, 8'd0, cyc, ec, pb);
        vectors++; if (cyc !== 2 || RESULT !== 8'd0 || acc !== 8'd0) begin errors++; $display("FAIL clear cyc=%0d res=%0d q=%0d exp 2/0/0", cyc, RESULT, acc); end
        run_cmd(OP_ADDN, 8'd3, 8'd1, cyc, ec, pb);
        vectors++; if (cyc !== 2 || RESULT !== 8'd1 || acc !== 8'd3) begin errors++; $display("FAIL add3 cyc=%0d res=%0d q=%0d exp 2/1/3", cyc, RESULT, acc); end
        run_cmd(OP_ADDN, 8'd7, 8'd1, cyc, ec, pb);
        vectors++; if (RESULT !== 8'd1 || acc !== 8'd10) begin errors++; $display("FAIL add7 res=%0d q=%0d exp 1/10", RESULT, acc); end
        run_cmd(OP_ADDN, 8'd10, 8'd5, cyc, ec, pb);
        vectors++; if (cyc !== 6 || ec !== 5 || RESULT !== 8'd5 || acc !== 8'd60 || pb) begin errors++; $display("FAIL add10x5 cyc=%0d e=%0d res=%0d q=%0d pb=%b exp 6/5/5/60/0", cyc, ec, RESULT, acc, pb); end
        run_cmd(OP_DIV, 8'd12, 8'd0, cyc, ec, pb);
        vectors++; if (cyc !== 6 || ec !== 5 || RESULT !== 8'd5 || acc !== 8'd0 || pb) begin errors++; $display("FAIL div60_12 cyc=%0d e=%0d res=%0d q=%0d pb=%b exp 6/5/5/0/0", cyc, ec, RESULT, acc, pb); end
    endtask

    task automatic test_sub();
        int cyc, ec; bit pb;
        run_cmd(OP_CLEAR, 8'd0, 8'd0, cyc, ec, pb);
        run_cmd(OP_ADDN, 8'd20, 8'd1, cyc, ec, pb);
        run_cmd(OP_SUBN, 8'd3, 8'd4, cyc, ec, pb);
        vectors++; if (cyc !== 5 || ec !== 4 || RESULT !== 8'd4 || acc !== 8'd8 || OVF !== 1'b0 || pb) begin errors++; $display("FAIL sub3x4 cyc=%0d e=%0d res=%0d q=%0d ovf=%b pb=%b exp 5/4/4/8/0/0", cyc, ec, RESULT, acc, OVF, pb); end
    endtask

    task automatic test_div();
        int cyc, ec; bit pb;
        run_cmd(OP_CLEAR, 8'd0, 8'd0, cyc, ec, pb);
        run_cmd(OP_ADDN, 8'd50, 8'd1, cyc, ec, pb);
        run_cmd(OP_DIV, 8'd7, 8'd0, cyc, ec, pb);
        vectors++; if (cyc !== 8 || ec !== 7 || RESULT !== 8'd7 || acc !== 8'd1 || pb) begin errors++; $display("FAIL div50_7 cyc=%0d e=%0d res=%0d q=%0d pb=%b exp 8/7/7/1/0", cyc, ec, RESULT, acc, pb); end
        run_cmd(OP_CLEAR, 8'd0, 8'd0, cyc, ec, pb);
        run_cmd(OP_ADDN, 8'd5, 8'd1, cyc, ec, pb);
        run_cmd(OP_DIV, 8'd12, 8'd0, cyc, ec, pb);
        vectors++; if (cyc !== 1 || ec !== 0 || RESULT !== 8'd0 || acc !== 8'd5 || DZ !== 1'b0) begin errors++; $display("FAIL div5_12 cyc=%0d e=%0d res=%0d q=%0d dz=%b exp 1/0/0/5/0", cyc, ec, RESULT, acc, DZ); end
    endtask

    task automatic test_div_zero();
        int cyc, ec; bit pb;
        run_cmd(OP_DIV, 8'd0, 8'd0, cyc, ec, pb);
        vectors++; if (cyc !== 1 || ec !== 0 || DZ !== 1'b1 || RESULT !== 8'd0 || acc !== 8'd5) begin errors++; $display("FAIL div_zero cyc=%0d e=%0d dz=%b res=%0d q=%0d exp 1/0/1/0/5", cyc, ec, DZ, RESULT, acc); end
    endtask

    task automatic test_overflow();
        int cyc, ec; bit pb;
        run_cmd(OP_CLEAR, 8'd0, 8'd0, cyc, ec, pb);
        run_cmd(OP_ADDN, 8'd100, 8'd3, cyc, ec, pb);
`ifdef ACCUM_SEQ_OVF_EN
        vectors++; if (cyc !== 4 || ec !== 2 || RESULT !== 8'd2 || OVF !== 1'b1 || acc !== 8'd200) begin errors++; $display("FAIL ovf_abort cyc=%0d e=%0d res=%0d ovf=%b q=%0d exp 4/2/2/1/200", cyc, ec, RESULT, OVF, acc); end
`else
        vectors++; if (cyc !== 4 || ec !== 3 || RESULT !== 8'd3 || OVF !== 1'b0 || acc !== 8'd44) begin errors++; $display("FAIL ovf_wrap cyc=%0d e=%0d res=%0d ovf=%b q=%0d exp 4/3/3/0/44", cyc, ec, RESULT, OVF, acc); end
`endif
    endtask

    task automatic test_zero_n();
        int cyc, ec; bit pb;
        run_cmd(OP_ADDN, 8'd9, 8'd0, cyc, ec, pb);
        vectors++; if (cyc !== 1 || ec !== 0 || RESULT !== 8'd0) begin errors++; $display("FAIL zero_n cyc=%0d e=%0d res=%0d exp 1/0/0", cyc, ec, RESULT); end
    endtask

    task automatic test_back_to_back();
        int cyc, ec; bit pb;
        int ready_cyc, dones, ecnt, done2;
        run_cmd(OP_CLEAR, 8'd0, 8'd0, cyc, ec, pb);
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_OP = OP_ADDN; CMD_B = 8'd2; CMD_N = 8'd3;
        @(posedge CLK);
        #1 CMD_B = 8'd1; CMD_N = 8'd4;
        ready_cyc = -1; dones = 0; ecnt = 0; done2 = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge CLK);
            if (E) ecnt++;
            if (DONE) dones++;
            if (CMD_READY) begin
                ready_cyc = i;
                @(posedge CLK);
                #1 CMD_VALID = 1'b0;
                break;
            end
        end
        vectors++; if (ready_cyc !== 5 || dones !== 1) begin errors++; $display("FAIL busy_hold ready_cyc=%0d dones=%0d exp 5/1", ready_cyc, dones); end
        for (int i = 1; i <= 50; i++) begin
            @(negedge CLK);
            if (E) ecnt++;
            if (DONE) begin done2 = i; break; end
        end
        vectors++; if (done2 !== 5 || RESULT !== 8'd4 || acc !== 8'd10 || ecnt !== 7) begin errors++; $display("FAIL second_cmd done=%0d res=%0d q=%0d e=%0d exp 5/4/10/7", done2, RESULT, acc, ecnt); end
        dones = 0; ecnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (E) ecnt++;
            if (DONE) dones++;
        end
        vectors++; if (dones !== 0 || ecnt !== 0 || acc !== 8'd10 || CMD_READY !== 1'b1) begin errors++; $display("FAIL executed_once dones=%0d e=%0d q=%0d ready=%b exp 0/0/10/1", dones, ecnt, acc, CMD_READY); end
    endtask

    task automatic test_reset_mid();
        int cyc, ec, dones; bit pb;
        run_cmd(OP_CLEAR, 8'd0, 8'd0, cyc, ec, pb);
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_OP = OP_ADDN; CMD_B = 8'd1; CMD_N = 8'd10;
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        @(posedge CLK);
        #1 CLR_N = 1'b0;
        #1;
        vectors++; if (E !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL rst_mid_async E=%b DONE=%b exp 0/0", E, DONE); end
        dones = 0;
        repeat (3) begin
            @(negedge CLK);
            if (DONE || E) dones++;
        end
        CLR_N = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (DONE || E) dones++;
        end
        vectors++; if (dones !== 0 || acc !== 8'd4 || CMD_READY !== 1'b1 || RESULT !== 8'd0) begin errors++; $display("FAIL rst_mid_after activity=%0d q=%0d ready=%b res=%0d exp 0/4/1/0", dones, acc, CMD_READY, RESULT); end
    endtask

    initial begin
        test_reset();
        test_clear_add_div();
        test_sub();
        test_div();
        test_div_zero();
        test_overflow();
        test_zero_n();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/accum_seq.md
Name: accum_seq

Overview:
- Command sequencer that sits directly upstream of the ALU accumulator and drives its operand (B), enable (E) and add/subtract select (S) inputs.
- Accepts one command at a time through a valid/ready handshake and runs it to completion:
  - clear the accumulator;
  - add B repeatedly N times;
  - subtract B repeatedly N times;
  - divide by repeated subtraction, counting steps.
- Monitors the accumulator output Q to end the divide and reports the step count.

Parameters:
- WIDTH, 8, data width of B and Q
- CNT_W, 8, width of the repeat count CMD_N and of RESULT

Ports:
- CLK  in  1  system clock, rising edge
- CLR_N  in  1  asynchronous active-low reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  sequencer idle, command can be accepted
- CMD_OP  in  2  operation: 00 CLEAR, 01 ADDN, 10 SUBN, 11 DIV
- CMD_B  in  WIDTH  operand
- CMD_N  in  CNT_W  repeat count for ADDN/SUBN; ignored for CLEAR and DIV
- Q  in  WIDTH  current accumulator value, fed back from the accumulator
- B  out  WIDTH  operand to the accumulator
- E  out  1  accumulator enable
- S  out  1  accumulator select: 0 add, 1 subtract
- ACC_CLR  out  1  accumulator clear, active-high, one cycle
- DONE  out  1  one-cycle completion pulse
- RESULT  out  CNT_W  number of accumulator updates performed by the last command
- DZ  out  1  divide-by-zero flag, valid with DONE
- OVF  out  1  overflow/underflow abort flag, valid with DONE

Behaviour:
- Accumulator contract:
  - On a CLK rising edge with E=1, Q <= Q+B (S=0) or Q-B (S=1), modulo 2^WIDTH.
  - ACC_CLR=1 forces Q to 0.
- Reset (CLR_N low, asynchronous): state IDLE; B=0, S=0, RESULT=0, DZ=0, OVF=0, cnt=0.
  - E, ACC_CLR and DONE drop to 0 immediately.
  - Reset mid-command abandons the command; no further E pulses.
- States: IDLE, CLRS, ADD, SUB, DIV, FIN.
- IDLE:
  - CMD_READY=1 in IDLE only.
  - On the accept edge (CMD_VALID & CMD_READY): latch CMD_B into B, set S (1 for SUBN/DIV, else 0), load cnt=CMD_N, clear RESULT/DZ/OVF.
  - Next state: CLEAR -> CLRS; ADDN -> ADD; SUBN -> SUB; DIV -> DIV.
- CLRS: ACC_CLR=1 for exactly one cycle -> FIN. RESULT=0.
- ADD/SUB:
  - E = (cnt != 0), combinational from state registers.
  - Each cycle with E=1: cnt--, RESULT++.
  - When cnt==0 -> FIN.
  - Exactly N accumulator updates. N=0 gives zero updates and goes straight to FIN.
- DIV:
  - B==0 at entry -> FIN with DZ=1, RESULT=0, no E.
  - Otherwise E = (Q >= B) combinationally each cycle. Q is sampled live, so one subtract occurs per cycle.
  - Each E cycle: RESULT++.
  - When Q < B -> FIN. RESULT = floor(Q0/B); Q ends at Q0 mod B.
  - Max RESULT is 2^WIDTH-1, which fits when CNT_W >= WIDTH; RESULT saturates at all-ones otherwise.
- FIN: DONE=1 for one cycle, E=0 -> IDLE. RESULT/DZ/OVF hold until the next accept.
- Latency:
  - ADDN/SUBN: DONE in cycle N+1 after the accept edge.
  - CLEAR: DONE in cycle 2.
  - DIV: DONE in cycle q+1, where q is the quotient.
  - CMD_READY returns the cycle after DONE; back-to-back commands have one idle cycle between them.
- B and S are stable for the whole command. E is never asserted in IDLE or FIN.
- CMD_VALID while busy is ignored and not queued. The master holds it until READY.

Optional Feature:
- Macro: ACCUM_SEQ_OVF_EN.
- Defined:
  - In ADD, a cycle where Q+B > 2^WIDTH-1 suppresses E and goes to FIN with OVF=1.
  - In SUB, a cycle where B > Q does the same.
  - RESULT counts only the completed updates.
- Undefined: arithmetic wraps modulo 2^WIDTH, all N updates are issued, and OVF is tied 0.

Test Plan:
- Sequence CLEAR; ADDN B=3 N=1; ADDN B=7 N=1; ADDN B=10 N=5 -> Q=60, each DONE with RESULT 0,1,1,5; then DIV B=12 -> 5 E cycles, DONE with RESULT=5, Q=0.
- DIV B=7 with Q=50 -> RESULT=7, Q=1, S=1 throughout; DIV with Q=5, B=12 -> zero E cycles, DONE in cycle 1, RESULT=0.
- DIV B=0 -> no E, DONE in cycle 1, DZ=1, RESULT=0, Q unchanged.
- ADDN B=100 N=3 from Q=0:
  - With ACCUM_SEQ_OVF_EN: 2 updates, OVF=1, RESULT=2, Q=200.
  - Without it: Q=44 (wrapped), RESULT=3, OVF=0.
- ADDN N=0 -> no E, DONE next cycle, RESULT=0; CMD_VALID held during a busy command -> not accepted until READY, executed exactly once.
- Assert CLR_N low mid ADDN B=1 N=10 after 4 updates -> E drops immediately, no DONE, Q=4 (accumulator untouched), READY=1 after release.
